jw_ram_writer: RTL and testbench



---
 rtl/jw_pkg.sv | 37 +++
 rtl/nmea_checksum.sv | 50 +++++
 rtl/jw_ram_writer.sv | 224 ++++++++++++++++++++++
 tb/tb_jw_ram_writer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jw_pkg.sv
// Shared constants and state encoding for the GPS lat/long digit RAM writer.
// ASCII codes, RMC field numbers and the digit RAM layout live here.
package jw_pkg;

  localparam logic [7:0] ASC_DOLLAR = 8'h24;
  localparam logic [7:0] ASC_COMMA  = 8'h2C;
  localparam logic [7:0] ASC_STAR   = 8'h2A;
  localparam logic [7:0] ASC_DOT    = 8'h2E;
  localparam logic [7:0] ASC_A      = 8'h41;
  localparam logic [7:0] ASC_ZERO   = 8'h30;
  localparam logic [7:0] ASC_NINE   = 8'h39;
  localparam logic [7:0] ASC_G      = 8'h47;
  localparam logic [7:0] ASC_P      = 8'h50;
  localparam logic [7:0] ASC_N      = 8'h4E;
  localparam logic [7:0] ASC_R      = 8'h52;
  localparam logic [7:0] ASC_M      = 8'h4D;
  localparam logic [7:0] ASC_C      = 8'h43;

  localparam logic [3:0] FLD_STATUS = 4'd2;
  localparam logic [3:0] FLD_LAT    = 4'd3;
  localparam logic [3:0] FLD_LON    = 4'd5;

  localparam int         JW_ENTRIES       = 10;
  localparam int         DIGITS_PER_FIELD = 5;
  localparam logic [3:0] LAT_BASE         = 4'd0;
  localparam logic [3:0] LON_BASE         = 4'd5;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    FIELDS,
    CK1,
    CK2,
    COMMIT
  } jw_state_e;

endpackage

// File: rtl/nmea_checksum.sv
// Running XOR of sentence bytes plus hex-ASCII decode of the two trailing
// checksum characters; match compares against the high nibble held from CK1.
module nmea_checksum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic       hi_load,
  input  logic [7:0] din,
  output logic       hex_ok,
  output logic       match
);

  logic [7:0] acc_reg;
  logic [3:0] hi_reg;

  function automatic logic is_hex(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) ||
           (c >= 8'h41 && c <= 8'h46) ||
           (c >= 8'h61 && c <= 8'h66);
  endfunction

  // Letters A-F and a-f both have low nibble 1..6, so +9 maps them to 10..15.
  function automatic logic [3:0] hex_nib(input logic [7:0] c);
    if (c <= 8'h39) return c[3:0];
    return c[3:0] + 4'd9;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= 8'h00;
      hi_reg  <= 4'h0;
    end else begin
      if (clear) begin
        acc_reg <= 8'h00;
      end else if (enable) begin
        acc_reg <= acc_reg ^ din;
      end
      if (hi_load) begin
        hi_reg <= hex_nib(din);
      end
    end
  end

  always_comb begin
    hex_ok = is_hex(din);
    match  = (acc_reg == {hi_reg, hex_nib(din)});
  end

endmodule

// File: rtl/jw_ram_writer.sv
// Parses $GPRMC/$GNRMC from the UART byte stream and, for a checksum-correct
// fix, writes 5 latitude and 5 longitude BCD digits into the display RAM.
module jw_ram_writer
  import jw_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int MAX_LEN = 82
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              ram_we,
  output logic [3:0]        ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              frame_ok,
  output logic              frame_err,
  output logic              fix_valid
);

  localparam int         CNT_W     = $clog2(MAX_LEN + 1);
  localparam logic [3:0] LAST_ADDR = 4'(JW_ENTRIES - 1);
  localparam logic [2:0] FULL_CNT  = 3'(DIGITS_PER_FIELD);

  jw_state_e        state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       hdr_idx_reg;
  logic [3:0]       field_reg;
  logic [3:0]       char_idx_reg;
  logic [2:0]       lat_cnt_reg;
  logic [2:0]       lon_cnt_reg;
  logic             status_a_reg;
  logic             bad_reg;
  logic             ck_bad_reg;
  logic [3:0]       shadow_reg [JW_ENTRIES];

  logic             parsing;
  logic             is_dollar;
  logic             byte_evt;
  logic             is_digit;
  logic             hdr_match;
  logic             lat_slot;
  logic             lon_slot;
  logic             cap_en;
  logic [3:0]       cap_idx;
  logic             cs_clear;
  logic             cs_enable;
  logic             cs_hi_load;
  logic             hex_ok;
  logic             ck_match;
  logic             ck_good;
  logic             sentence_good;

  always_comb begin
    parsing   = (state_reg == HDR) || (state_reg == FIELDS) ||
                (state_reg == CK1) || (state_reg == CK2);
    is_dollar = rx_valid && (state_reg != COMMIT) && (rx_data == ASC_DOLLAR);
    // A byte that advances the parser: not a restart and within the length budget.
    byte_evt  = rx_valid && parsing && (rx_data != ASC_DOLLAR) &&
                (cnt_reg < CNT_W'(MAX_LEN));
    is_digit  = (rx_data >= ASC_ZERO) && (rx_data <= ASC_NINE);

    hdr_match = 1'b0;
    case (hdr_idx_reg)
      3'd0:    hdr_match = (rx_data == ASC_G);
      3'd1:    hdr_match = (rx_data == ASC_P) || (rx_data == ASC_N);
      3'd2:    hdr_match = (rx_data == ASC_R);
      3'd3:    hdr_match = (rx_data == ASC_M);
      3'd4:    hdr_match = (rx_data == ASC_C);
      3'd5:    hdr_match = (rx_data == ASC_COMMA);
      default: hdr_match = 1'b0;
    endcase

    // Latitude skips char 4 (the decimal point); longitude takes the first five.
    lat_slot = (field_reg == FLD_LAT) && (lat_cnt_reg < FULL_CNT) &&
               ((char_idx_reg < 4'd4) || (char_idx_reg == 4'd5));
    lon_slot = (field_reg == FLD_LON) && (lon_cnt_reg < FULL_CNT) &&
               (char_idx_reg < 4'd5);
    cap_en   = byte_evt && (state_reg == FIELDS) && (rx_data != ASC_STAR) &&
               (rx_data != ASC_COMMA) && is_digit && (lat_slot || lon_slot);
    cap_idx  = lat_slot ? (LAT_BASE + {1'b0, lat_cnt_reg})
                        : (LON_BASE + {1'b0, lon_cnt_reg});

    cs_clear   = is_dollar;
    cs_enable  = byte_evt && ((state_reg == HDR) || (state_reg == FIELDS)) &&
                 (rx_data != ASC_STAR);
    cs_hi_load = byte_evt && (state_reg == CK1);

    ck_good       = hex_ok && ck_match && !ck_bad_reg;
    sentence_good = ck_good && status_a_reg && !bad_reg &&
                    (lat_cnt_reg == FULL_CNT) && (lon_cnt_reg == FULL_CNT);
  end

  nmea_checksum u_checksum (
    .clk     (clk),
    .rst     (rst),
    .clear   (cs_clear),
    .enable  (cs_enable),
    .hi_load (cs_hi_load),
    .din     (rx_data),
    .hex_ok  (hex_ok),
    .match   (ck_match)
  );

  genvar gi;
  generate
    for (gi = 0; gi < JW_ENTRIES; gi++) begin : g_shadow
      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_reg[gi] <= 4'd0;
        end else if (cap_en && (cap_idx == 4'(gi))) begin
          shadow_reg[gi] <= rx_data[3:0];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      hdr_idx_reg  <= 3'd0;
      field_reg    <= 4'd0;
      char_idx_reg <= 4'd0;
      lat_cnt_reg  <= 3'd0;
      lon_cnt_reg  <= 3'd0;
      status_a_reg <= 1'b0;
      bad_reg      <= 1'b0;
      ck_bad_reg   <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= 4'd0;
      ram_data     <= '0;
      frame_ok     <= 1'b0;
      frame_err    <= 1'b0;
      fix_valid    <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (state_reg == COMMIT) begin
        // Incoming bytes are ignored until the full 10-digit burst is out.
        if (ram_addr == LAST_ADDR) begin
          ram_we    <= 1'b0;
          frame_ok  <= 1'b1;
          state_reg <= IDLE;
        end else begin
          ram_addr <= ram_addr + 4'd1;
          ram_data <= DATA_W'(shadow_reg[ram_addr + 4'd1]);
        end
      end else if (is_dollar) begin
        state_reg    <= HDR;
        cnt_reg      <= CNT_W'(1);
        hdr_idx_reg  <= 3'd0;
        field_reg    <= 4'd0;
        char_idx_reg <= 4'd0;
        lat_cnt_reg  <= 3'd0;
        lon_cnt_reg  <= 3'd0;
        status_a_reg <= 1'b0;
        bad_reg      <= 1'b0;
        ck_bad_reg   <= 1'b0;
      end else if (rx_valid && parsing && !byte_evt) begin
        frame_err <= 1'b1;
        state_reg <= IDLE;
      end else if (byte_evt) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
        case (state_reg)
          HDR: begin
            if (!hdr_match) begin
              frame_err <= 1'b1;
              state_reg <= IDLE;
            end else if (hdr_idx_reg == 3'd5) begin
              state_reg    <= FIELDS;
              field_reg    <= 4'd1;
              char_idx_reg <= 4'd0;
            end else begin
              hdr_idx_reg <= hdr_idx_reg + 3'd1;
            end
          end
          FIELDS: begin
            if (rx_data == ASC_STAR) begin
              state_reg <= CK1;
            end else if (rx_data == ASC_COMMA) begin
              if (((field_reg == FLD_LAT) && (lat_cnt_reg != FULL_CNT)) ||
                  ((field_reg == FLD_LON) && (lon_cnt_reg != FULL_CNT))) begin
                bad_reg <= 1'b1;
              end
              if (field_reg != 4'hF) field_reg <= field_reg + 4'd1;
              char_idx_reg <= 4'd0;
            end else begin
              if (char_idx_reg != 4'hF) char_idx_reg <= char_idx_reg + 4'd1;
              if ((field_reg == FLD_STATUS) && (char_idx_reg == 4'd0)) begin
                status_a_reg <= (rx_data == ASC_A);
              end
              if (lat_slot) begin
                if (is_digit) lat_cnt_reg <= lat_cnt_reg + 3'd1;
                else          bad_reg     <= 1'b1;
              end else if (lon_slot) begin
                if (is_digit) lon_cnt_reg <= lon_cnt_reg + 3'd1;
                else          bad_reg     <= 1'b1;
              end
            end
          end
          CK1: begin
            if (!hex_ok) ck_bad_reg <= 1'b1;
            state_reg <= CK2;
          end
          CK2: begin
            if (ck_good) fix_valid <= status_a_reg;
            if (sentence_good) begin
              state_reg <= COMMIT;
              ram_we    <= 1'b1;
              ram_addr  <= 4'd0;
              ram_data  <= DATA_W'(shadow_reg[0]);
            end else begin
              frame_err <= 1'b1;
              state_reg <= IDLE;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jw_ram_writer.sv
// Bench for jw_ram_writer: directed and random RMC sentences checked against a
// string-level model of the sentence rules (fields, digits, checksum, length).
module tb_jw_ram_writer;

  localparam int DATA_W  = 4;
  localparam int MAX_LEN = 82;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              ram_we;
  logic [3:0]        ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              frame_ok;
  logic              frame_err;
  logic              fix_valid;

  jw_ram_writer #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .fix_valid (fix_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wcyc[$];
  int waddr[$];
  int wdata[$];
  int okcyc[$];
  int errcyc[$];

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      wcyc.push_back(cyc);
      waddr.push_back(int'(ram_addr));
      wdata.push_back(int'(ram_data));
    end
    if (frame_ok === 1'b1)  okcyc.push_back(cyc);
    if (frame_err === 1'b1) errcyc.push_back(cyc);
  end

  int errors = 0;
  int checks = 0;
  logic [31:0] fix_model = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int hexval(input byte c);
    if (c >= "0" && c <= "9") return c - "0";
    if (c >= "A" && c <= "F") return c - "A" + 10;
    if (c >= "a" && c <= "f") return c - "a" + 10;
    return -1;
  endfunction

  function automatic int xor_of(input string s);
    int x = 0;
    for (int i = 0; i < s.len(); i++) x = x ^ int'(s[i]);
    return x;
  endfunction

  function automatic string field_of(input string s, input int n);
    string r = "";
    int f = 0;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == ",") f++;
      else if (f == n) r = {r, string'(s[i])};
    end
    return r;
  endfunction

  function automatic bit digit_at(input string s, input int p, output int d);
    d = 0;
    if (p >= s.len()) return 1'b0;
    if (s[p] < "0" || s[p] > "9") return 1'b0;
    d = s[p] - "0";
    return 1'b1;
  endfunction

  // Outcome of one sentence: body is everything between '$' and '*'.
  function automatic void model(input string body, input string ck, output bit good,
                                output bit ck_ok, output bit stat_a, output int dig[10]);
    string hdr, st, lat, lon;
    int h, l;
    bit dig_ok = 1'b1;
    int lat_pos[5] = '{0, 1, 2, 3, 5};
    hdr = field_of(body, 0);
    st  = field_of(body, 2);
    lat = field_of(body, 3);
    lon = field_of(body, 5);
    h = hexval(ck[0]);
    l = hexval(ck[1]);
    ck_ok  = (hdr == "GPRMC" || hdr == "GNRMC") && (body.len() + 4 <= MAX_LEN) &&
             h >= 0 && l >= 0 && (h * 16 + l) == xor_of(body);
    stat_a = (st.len() > 0) && (st[0] == "A");
    for (int i = 0; i < 5; i++) begin
      if (!digit_at(lat, lat_pos[i], dig[i])) dig_ok = 1'b0;
      if (!digit_at(lon, i, dig[5 + i]))      dig_ok = 1'b0;
    end
    good = ck_ok && stat_a && dig_ok;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_sentence(input string body, input string ck, input int gap, output int last);
    send_byte(8'h24, gap);
    for (int i = 0; i < body.len(); i++) send_byte(body[i], gap);
    send_byte(8'h2A, gap);
    send_byte(ck[0], gap);
    send_byte(ck[1], 0);
    last = cyc;
  endtask

  function automatic string good_ck(input string body, input bit lower);
    return lower ? $sformatf("%02x", xor_of(body)) : $sformatf("%02X", xor_of(body));
  endfunction

  function automatic void clear_logs();
    wcyc.delete(); waddr.delete(); wdata.delete(); okcyc.delete(); errcyc.delete();
  endfunction

  task automatic run_case(input string tag, input string prefix, input string body,
                          input string ck, input int gap, input bit inject);
    bit good, ckm, sa;
    int dig[10];
    int last;
    model(body, ck, good, ckm, sa, dig);
    if (ckm) fix_model = 32'(sa);
    clear_logs();
    for (int i = 0; i < prefix.len(); i++) send_byte(prefix[i], 0);
    send_sentence(body, ck, gap, last);
    if (inject) send_byte(8'h24, 0);
    repeat (14) begin @(posedge clk); #1; end
    chk({tag, ":n_writes"}, wcyc.size(), good ? 10 : 0);
    for (int i = 0; i < wcyc.size() && i < 10; i++) begin
      chk($sformatf("%s:wr%0d_cyc", tag, i), wcyc[i], last + i);
      chk($sformatf("%s:wr%0d_addr", tag, i), waddr[i], i);
      chk($sformatf("%s:wr%0d_data", tag, i), wdata[i], dig[i]);
    end
    chk({tag, ":n_ok"}, okcyc.size(), good ? 1 : 0);
    if (good && okcyc.size() > 0) chk({tag, ":ok_cyc"}, okcyc[0], last + 10);
    chk({tag, ":n_err"}, errcyc.size(), good ? 0 : 1);
    if (!good && errcyc.size() > 0) chk({tag, ":err_cyc"}, errcyc[0], last);
    chk({tag, ":fix_valid"}, fix_valid, fix_model);
    $display("txn %s gap=%0d good=%0b writes=%0d ok=%0d err=%0d fix=%0b",
             tag, gap, good, wcyc.size(), okcyc.size(), errcyc.size(), fix_valid);
  endtask

  initial begin
    string canon, vbody, xbody, body2, ck, b, hs, st;
    int last, errexp, cs;

    canon = "GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W";

    // Reset state
    repeat (3) begin @(posedge clk); #1; end
    chk("rst:ram_we", ram_we, 0);
    chk("rst:ram_addr", ram_addr, 0);
    chk("rst:ram_data", ram_data, 0);
    chk("rst:frame_ok", frame_ok, 0);
    chk("rst:frame_err", frame_err, 0);
    chk("rst:fix_valid", fix_valid, 0);
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Canonical sentence, then wrong checksum, then status V
    run_case("canon", "", canon, good_ck(canon, 0), 0, 0);
    cs = xor_of(canon);
    ck = $sformatf("%02X", (cs & 8'hF0) | ((cs + 1) & 8'h0F));
    run_case("bad_ck", "", canon, ck, 0, 0);
    vbody = canon;
    vbody.putc(13, "V");
    run_case("status_v", "", vbody, good_ck(vbody, 0), 0, 0);

    // Non-digit latitude
    run_case("canon2", "", canon, good_ck(canon, 1), 0, 0);
    xbody = "GNRMC,123519,A,48X7.038,N,01131.000,E,022.4,084.4,230394,003.1,W";
    run_case("lat_x", "", xbody, good_ck(xbody, 0), 0, 0);

    // Restart on a second '$'
    body2 = "GNRMC,010203,A,5123.456,S,00012.345,W,000.0,000.0,010100,,";
    run_case("restart", "$GPRMC,123519,A,48", body2, good_ck(body2, 0), 0, 0);

    // Over-length sentence without '*'
    clear_logs();
    b = "GPRMC,";
    while (b.len() < 90) b = {b, "x"};
    send_byte(8'h24, 0);
    errexp = -1;
    for (int k = 1; k <= 90; k++) begin
      send_byte(b[k - 1], 0);
      if (k == MAX_LEN) errexp = cyc;
    end
    repeat (3) begin @(posedge clk); #1; end
    chk("ovf:n_err", errcyc.size(), 1);
    if (errcyc.size() > 0) chk("ovf:err_cyc", errcyc[0], errexp);
    chk("ovf:n_writes", wcyc.size(), 0);
    $display("txn overflow bytes=91 err=%0d", errcyc.size());

    // Reset during the 4th write cycle
    clear_logs();
    send_sentence(body2, good_ck(body2, 0), 0, last);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_commit:ram_we", ram_we, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    fix_model = 0;
    repeat (12) begin @(posedge clk); #1; end
    chk("rst_commit:n_writes", wcyc.size(), 4);
    chk("rst_commit:n_ok", okcyc.size(), 0);
    chk("rst_commit:n_err", errcyc.size(), 0);
    chk("rst_commit:fix_valid", fix_valid, fix_model);
    $display("txn reset_in_commit writes=%0d", wcyc.size());

    // '$' during COMMIT, then slow byte stream
    run_case("inject", "", canon, good_ck(canon, 0), 0, 1);
    run_case("gap500", "", canon, good_ck(canon, 0), 500, 0);

    // Random sentences
    for (int n = 0; n < 16; n++) begin
      hs = ($urandom_range(1) == 1) ? "P" : "N";
      st = ($urandom_range(3) == 0) ? "V" : "A";
      b = $sformatf("G%sRMC,%06d,%s,%02d%02d.%03d,N,%03d%02d.%03d,E,022.4,084.4,230394,003.1,W",
                    hs, $urandom_range(235959), st, $urandom_range(89), $urandom_range(59),
                    $urandom_range(999), $urandom_range(179), $urandom_range(59),
                    $urandom_range(999));
      if ($urandom_range(5) == 0) b.putc(15 + $urandom_range(19), "X");
      cs = xor_of(b);
      if ($urandom_range(4) == 0) cs = (cs & 8'hF0) | ((cs + 1) & 8'h0F);
      ck = ($urandom_range(1) == 1) ? $sformatf("%02x", cs) : $sformatf("%02X", cs);
      run_case($sformatf("rnd%0d", n), "", b, ck, $urandom_range(2), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
